// File: rtl/hazard_ctrl.sv
// Hazard/sequencing control for the 5-stage pipeline: load-use stalls,
// taken-branch flushes, multi-cycle op freeze. Optional: HAZ_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int LOAD_STALL = 1,
  parameter int MD_CYCLES  = 4,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_ID,
  input  logic [4:0]       rt_ID,
  input  logic             uses_rs_ID,
  input  logic             uses_rt_ID,
  input  logic [4:0]       rt_IDEX,
  input  logic             MemtoReg_IDEX,
  input  logic             branch_taken_EX,
  input  logic             md_start_ID,
  output logic             stall_PC,
  output logic             stall_IFID,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic             md_busy,
  output logic [CNT_W-1:0] md_cnt
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_events
`endif
);

  typedef enum logic [1:0] {
    RUN,
    LD_STALL,
    BR_FLUSH,
    MD_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] LS_INIT = CNT_W'(LOAD_STALL - 1);
  localparam logic [CNT_W-1:0] MD_INIT = CNT_W'(MD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use;
  logic             rs_hit, rt_hit;

  assign rs_hit   = uses_rs_ID && (rs_ID == rt_IDEX);
  assign rt_hit   = uses_rt_ID && (rt_ID == rt_IDEX);
  assign load_use = MemtoReg_IDEX && (rt_IDEX != 5'd0)
                    && (rs_hit || rt_hit);

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_PC   = 1'b0;
    stall_IFID = 1'b0;
    flush_IFID = 1'b0;
    flush_IDEX = 1'b0;
    md_busy    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (branch_taken_EX) begin
          flush_IFID = 1'b1;
          flush_IDEX = 1'b1;
          state_d    = BR_FLUSH;
        end else if (load_use) begin
          stall_PC   = 1'b1;
          stall_IFID = 1'b1;
          flush_IDEX = 1'b1;
          if (LOAD_STALL > 1) begin
            state_d = LD_STALL;
            cnt_d   = LS_INIT;
          end
        end else if (md_start_ID) begin
          state_d = MD_WAIT;
          cnt_d   = MD_INIT;
        end
      end
      LD_STALL: begin
        stall_PC   = 1'b1;
        stall_IFID = 1'b1;
        flush_IDEX = 1'b1;
        if (cnt_q <= ONE) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      BR_FLUSH: begin
        state_d = RUN;
        cnt_d   = '0;
      end
      MD_WAIT: begin
        stall_PC   = 1'b1;
        stall_IFID = 1'b1;
        flush_IDEX = 1'b1;
        md_busy    = 1'b1;
        if (cnt_q <= ONE) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    // Reset drains both front-end registers regardless of state
    if (!rst) begin
      stall_PC   = 1'b0;
      stall_IFID = 1'b0;
      flush_IFID = 1'b1;
      flush_IDEX = 1'b1;
      md_busy    = 1'b0;
    end
  end

  assign md_cnt = cnt_q;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles_q, flush_events_q;

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (stall_PC && (stall_cycles_q != 32'hFFFF_FFFF))
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if ((state_q == RUN) && branch_taken_EX
          && (flush_events_q != 32'hFFFF_FFFF))
        flush_events_q <= flush_events_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus hand sequences
// for reset-mid-op, LOAD_STALL=3 and the perf counters.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] rs_ID, rt_ID, rt_IDEX;
  logic       uses_rs_ID, uses_rt_ID;
  logic       MemtoReg_IDEX, branch_taken_EX, md_start_ID;

  logic       stall_PC, stall_IFID, flush_IFID, flush_IDEX, md_busy;
  logic [3:0] md_cnt;
  logic       b_stall_PC, b_stall_IFID, b_flush_IFID, b_flush_IDEX;
  logic       b_md_busy;
  logic [3:0] b_md_cnt;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
  logic [31:0] b_stall_cycles, b_flush_events;
`endif

  hazard_ctrl #(.LOAD_STALL(1), .MD_CYCLES(4), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst),
    .rs_ID(rs_ID), .rt_ID(rt_ID),
    .uses_rs_ID(uses_rs_ID), .uses_rt_ID(uses_rt_ID),
    .rt_IDEX(rt_IDEX), .MemtoReg_IDEX(MemtoReg_IDEX),
    .branch_taken_EX(branch_taken_EX), .md_start_ID(md_start_ID),
    .stall_PC(stall_PC), .stall_IFID(stall_IFID),
    .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
    .md_busy(md_busy), .md_cnt(md_cnt)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  hazard_ctrl #(.LOAD_STALL(3), .MD_CYCLES(4), .CNT_W(4)) u_ls3 (
    .clk(clk), .rst(rst),
    .rs_ID(rs_ID), .rt_ID(rt_ID),
    .uses_rs_ID(uses_rs_ID), .uses_rt_ID(uses_rt_ID),
    .rt_IDEX(rt_IDEX), .MemtoReg_IDEX(MemtoReg_IDEX),
    .branch_taken_EX(branch_taken_EX), .md_start_ID(md_start_ID),
    .stall_PC(b_stall_PC), .stall_IFID(b_stall_IFID),
    .flush_IFID(b_flush_IFID), .flush_IDEX(b_flush_IDEX),
    .md_busy(b_md_busy), .md_cnt(b_md_cnt)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cycles(b_stall_cycles), .flush_events(b_flush_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stall_PC, stall_IFID, flush_IFID, flush_IDEX, md_busy, md_cnt}
  localparam logic [8:0] E0   = 9'b00_0_0_0_0000;
  localparam logic [8:0] ELU  = 9'b11_0_1_0_0000;
  localparam logic [8:0] EBR  = 9'b00_1_1_0_0000;
  localparam logic [8:0] ERST = 9'b00_1_1_0_0000;
  localparam logic [8:0] EMD  = 9'b11_0_1_1_0000;

  typedef struct {
    string      name;
    logic [4:0] rs, rt, rtx;
    logic       urs, urt, mem, br, md;
    logic [8:0] exp;
  } vec_t;

  vec_t       vecs[18];
  logic [8:0] sb[$];
  string      sb_name[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  function automatic vec_t mk(string n, logic [4:0] rs, logic [4:0] rt,
                              logic [4:0] rtx, logic urs, logic urt,
                              logic mem, logic br, logic md,
                              logic [8:0] e);
    vec_t v;
    v.name = n; v.rs = rs; v.rt = rt; v.rtx = rtx;
    v.urs = urs; v.urt = urt; v.mem = mem; v.br = br; v.md = md;
    v.exp = e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rs_ID = v.rs; rt_ID = v.rt; rt_IDEX = v.rtx;
    uses_rs_ID = v.urs; uses_rt_ID = v.urt;
    MemtoReg_IDEX = v.mem; branch_taken_EX = v.br;
    md_start_ID = v.md;
  endtask

  task automatic check_out(input int which);
    logic [8:0] e, g;
    string      nm;
    e  = sb.pop_front();
    nm = sb_name.pop_front();
    if (which == 0)
      g = {stall_PC, stall_IFID, flush_IFID, flush_IDEX, md_busy, md_cnt};
    else
      g = {b_stall_PC, b_stall_IFID, b_flush_IFID, b_flush_IDEX,
           b_md_busy, b_md_cnt};
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, g, e);
    end
  endtask

  task automatic step(input vec_t v, input int which);
    @(posedge clk);
    drive(v);
    sb.push_back(v.exp);
    sb_name.push_back(v.name);
    #2;
    check_out(which);
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    rst = 1'b0;
    drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, E0));
    #2;
    sb.push_back(ERST);
    sb_name.push_back(nm);
    check_out(0);
    @(negedge clk);
    @(posedge clk);
    rst = 1'b1;
  endtask

  vec_t idle, lu, wild;

  initial begin
    idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, E0);
    lu   = mk("lu", 8, 0, 8, 1, 0, 1, 0, 0, ELU);
    wild = mk("wild", 8, 0, 8, 1, 0, 1, 1, 1, E0);

    vecs[0]  = mk("idle0",    0, 0, 0, 0, 0, 0, 0, 0, E0);
    vecs[1]  = mk("lu_rs",    8, 0, 8, 1, 0, 1, 0, 0, ELU);
    vecs[2]  = mk("lu_done",  8, 0, 8, 1, 0, 0, 0, 0, E0);
    vecs[3]  = mk("lu_rt",    0, 5, 5, 0, 1, 1, 0, 0, ELU);
    vecs[4]  = mk("r0_nohaz", 0, 0, 0, 1, 1, 1, 0, 0, E0);
    vecs[5]  = mk("no_use",   8, 8, 8, 0, 0, 1, 0, 0, E0);
    vecs[6]  = mk("br_prio",  8, 0, 8, 1, 0, 1, 1, 1, EBR);
    vecs[7]  = mk("br_flush", 8, 0, 8, 1, 0, 1, 1, 1, E0);
    vecs[8]  = mk("run_idle", 0, 0, 0, 0, 0, 0, 0, 0, E0);
    vecs[9]  = mk("md_start", 0, 0, 0, 0, 0, 0, 0, 1, E0);
    vecs[10] = mk("md_w3",    8, 0, 8, 1, 0, 1, 1, 1, EMD | 9'd3);
    vecs[11] = mk("md_w2",    8, 0, 8, 1, 0, 1, 1, 1, EMD | 9'd2);
    vecs[12] = mk("md_w1",    8, 0, 8, 1, 0, 1, 1, 1, EMD | 9'd1);
    vecs[13] = mk("md_done",  0, 0, 0, 0, 0, 0, 0, 0, E0);
    vecs[14] = mk("b2b_1",    3, 0, 3, 1, 0, 1, 0, 0, ELU);
    vecs[15] = mk("b2b_2",    0, 3, 3, 0, 1, 1, 0, 0, ELU);
    vecs[16] = mk("b2b_done", 0, 3, 3, 0, 1, 0, 0, 0, E0);
    vecs[17] = mk("nomem",    9, 0, 9, 1, 0, 0, 0, 0, E0);

    rst = 1'b0;
    drive(idle);
    #2;
    sb.push_back(ERST);
    sb_name.push_back("reset_init");
    check_out(0);
    @(negedge clk);
    @(posedge clk);
    rst = 1'b1;

    foreach (vecs[i]) step(vecs[i], 0);

    // Reset asserted in MD_WAIT while md_cnt==2
    step(mk("md_go", 0, 0, 0, 0, 0, 0, 0, 1, E0), 0);
    step(mk("md_a3", 0, 0, 0, 0, 0, 0, 0, 0, EMD | 9'd3), 0);
    step(mk("md_a2", 0, 0, 0, 0, 0, 0, 0, 0, EMD | 9'd2), 0);
    rst = 1'b0;
    #1;
    sb.push_back(ERST);
    sb_name.push_back("rst_mid_md");
    check_out(0);
    @(negedge clk);
    @(posedge clk);
    rst = 1'b1;
    step(mk("post_rst1", 0, 0, 0, 0, 0, 0, 0, 0, E0), 0);
    step(mk("post_rst2", 0, 0, 0, 0, 0, 0, 0, 0, E0), 0);

    // LOAD_STALL=3 instance: three stall cycles, branch ignored
    do_reset("reset_ls3");
    step(mk("ls3_c0", 8, 0, 8, 1, 0, 1, 0, 0, ELU), 1);
    step(mk("ls3_c1", 8, 0, 8, 1, 0, 1, 1, 0, ELU | 9'd2), 1);
    step(mk("ls3_c2", 0, 0, 0, 0, 0, 0, 1, 1, ELU | 9'd1), 1);
    step(mk("ls3_done", 0, 0, 0, 0, 0, 0, 0, 0, E0), 1);

    // Counter scenario: one load-use, one MD op, one taken branch
    do_reset("reset_perf");
    step(lu, 0);
    step(idle, 0);
    step(mk("p_md", 0, 0, 0, 0, 0, 0, 0, 1, E0), 0);
    step(mk("p_md3", 0, 0, 0, 0, 0, 0, 0, 0, EMD | 9'd3), 0);
    step(mk("p_md2", 0, 0, 0, 0, 0, 0, 0, 0, EMD | 9'd2), 0);
    step(mk("p_md1", 0, 0, 0, 0, 0, 0, 0, 0, EMD | 9'd1), 0);
    step(idle, 0);
    step(mk("p_br", 0, 0, 0, 0, 0, 0, 1, 0, EBR), 0);
    step(wild, 0);
    step(idle, 0);
`ifdef HAZ_PERF_CNT_EN
    n_tests++;
    if (stall_cycles !== 32'd4) begin
      n_fail++;
      $display("FAIL stall_cycles: got %0d expected 4", stall_cycles);
    end
    n_tests++;
    if (flush_events !== 32'd1) begin
      n_fail++;
      $display("FAIL flush_events: got %0d expected 1", flush_events);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
